// File: rtl/level_pkg.sv
// Shared definitions for the level sequencer.
// Holds the game FSM state encoding and the default values of every tunable
// parameter, so the top and the bench agree on one set of numbers.
package level_pkg;

  typedef enum logic [1:0] {
    StWait = 2'd0,
    StPlay = 2'd1,
    StWon  = 2'd2,
    StLost = 2'd3
  } state_e;

  localparam int unsigned DefNumLevels   = 15;
  localparam int unsigned DefLevelW      = 4;
  localparam int unsigned DefSpeedW      = 6;
  localparam int unsigned DefBlockW      = 3;
  localparam int unsigned DefSpeedStart  = 60;
  localparam int unsigned DefSpeedStep   = 4;
  localparam int unsigned DefSpeedMin    = 6;
  localparam int unsigned DefBlocksStart = 3;
  localparam int unsigned DefShrinkEvery = 5;

endpackage

// File: rtl/step_timer.sv
// Frame-tick divider that produces the block-advance pulse.
// Ports:
//   clk        - system clock, rising edge
//   resetn     - asynchronous reset, active high
//   enable     - count only while high; low clears the count and any pending step
//   frame_tick - one-cycle frame strobe
//   limit      - ticks per step (must be >= 1)
//   step       - registered one-cycle pulse after the tick that reaches limit
module step_timer #(
  parameter int unsigned W = 6
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         enable,
  input  logic         frame_tick,
  input  logic [W-1:0] limit,
  output logic         step
);

  logic [W-1:0] count_d, count_q;
  logic         step_d, step_q;

  always_comb begin
    count_d = count_q;
    step_d  = 1'b0;
    if (!enable) begin
      // Ticks coincident with leaving PLAY are dropped here as well.
      count_d = '0;
    end else if (frame_tick) begin
      if (count_q == limit - W'(1)) begin
        count_d = '0;
        step_d  = 1'b1;
      end else begin
        count_d = count_q + W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      count_q <= '0;
      step_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      step_q  <= step_d;
    end
  end

  assign step = step_q;

endmodule

// File: rtl/level_sequencer.sv
// Game level sequencer: WAIT/PLAY/WON/LOST flow, per-level speed and block
// width, and the block step pulse while playing.
// Ports:
//   clk, resetn             - clock and asynchronous active-high reset
//   go                      - start/continue request (level-sensitive)
//   next_signal, miss       - level cleared / failed placement pulses
//   frame_tick              - frame strobe feeding the step timer
//   speed_count, num_blocks - current level's ticks per step and block width
//   curr_level              - current level, 1-based
//   active, game_won, game_over - registered state flags
//   step                    - one-cycle block-advance pulse (PLAY only)
module level_sequencer
  import level_pkg::*;
#(
  parameter int unsigned NUM_LEVELS   = DefNumLevels,
  parameter int unsigned LEVEL_W      = DefLevelW,
  parameter int unsigned SPEED_W      = DefSpeedW,
  parameter int unsigned BLOCK_W      = DefBlockW,
  parameter int unsigned SPEED_START  = DefSpeedStart,
  parameter int unsigned SPEED_STEP   = DefSpeedStep,
  parameter int unsigned SPEED_MIN    = DefSpeedMin,
  parameter int unsigned BLOCKS_START = DefBlocksStart,
  parameter int unsigned SHRINK_EVERY = DefShrinkEvery
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               go,
  input  logic               next_signal,
  input  logic               miss,
  input  logic               frame_tick,
  output logic [SPEED_W-1:0] speed_count,
  output logic [BLOCK_W-1:0] num_blocks,
  output logic [LEVEL_W-1:0] curr_level,
  output logic               active,
  output logic               step,
  output logic               game_won,
  output logic               game_over
);

  if (NUM_LEVELS < 2 || NUM_LEVELS > (1 << LEVEL_W) - 1) begin : g_bad_levels
    $error("NUM_LEVELS out of range");
  end
  if (SPEED_START >= (1 << SPEED_W)) begin : g_bad_start
    $error("SPEED_START does not fit in SPEED_W");
  end
  if (SPEED_MIN < 1 || SPEED_MIN > SPEED_START) begin : g_bad_min
    $error("SPEED_MIN out of range");
  end
  if (BLOCKS_START < 1 || BLOCKS_START > (1 << BLOCK_W) - 1) begin : g_bad_blocks
    $error("BLOCKS_START out of range");
  end
  if (SHRINK_EVERY < 1) begin : g_bad_shrink
    $error("SHRINK_EVERY must be at least 1");
  end

  localparam int unsigned ShrW = (SHRINK_EVERY > 1) ? $clog2(SHRINK_EVERY) : 1;

  state_e             state_d, state_q;
  logic [LEVEL_W-1:0] level_d, level_q;
  logic [SPEED_W-1:0] speed_d, speed_q;
  logic [BLOCK_W-1:0] blocks_d, blocks_q;
  // Levels advanced since the last block shrink; replaces a divide by SHRINK_EVERY.
  logic [ShrW-1:0]    shrink_d, shrink_q;
  logic               active_q, won_q, over_q;
  logic               timer_en;

  always_comb begin
    state_d  = state_q;
    level_d  = level_q;
    speed_d  = speed_q;
    blocks_d = blocks_q;
    shrink_d = shrink_q;
    unique case (state_q)
      StWait: if (go) state_d = StPlay;
      StPlay: begin
        if (miss) begin
          state_d = StLost;
        end else if (next_signal) begin
          if (level_q < LEVEL_W'(NUM_LEVELS)) begin
            state_d = StWait;
            level_d = level_q + LEVEL_W'(1);
            // Saturate at SPEED_MIN without ever forming a negative value.
            if (32'(speed_q) >= SPEED_MIN + SPEED_STEP) begin
              speed_d = speed_q - SPEED_W'(SPEED_STEP);
            end else begin
              speed_d = SPEED_W'(SPEED_MIN);
            end
            if (shrink_q == ShrW'(SHRINK_EVERY - 1)) begin
              shrink_d = '0;
              if (blocks_q > BLOCK_W'(1)) blocks_d = blocks_q - BLOCK_W'(1);
            end else begin
              shrink_d = shrink_q + ShrW'(1);
            end
          end else begin
            state_d = StWon;
          end
        end
      end
      StWon, StLost: begin
        if (go) begin
          state_d  = StWait;
          level_d  = LEVEL_W'(1);
          speed_d  = SPEED_W'(SPEED_START);
          blocks_d = BLOCK_W'(BLOCKS_START);
          shrink_d = '0;
        end
      end
      default: state_d = StWait;
    endcase
  end

  // Count only while PLAY persists across the edge, so entry and exit both clear.
  assign timer_en = (state_q == StPlay) && (state_d == StPlay);

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state_q  <= StWait;
      level_q  <= LEVEL_W'(1);
      speed_q  <= SPEED_W'(SPEED_START);
      blocks_q <= BLOCK_W'(BLOCKS_START);
      shrink_q <= '0;
      active_q <= 1'b0;
      won_q    <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      speed_q  <= speed_d;
      blocks_q <= blocks_d;
      shrink_q <= shrink_d;
      active_q <= (state_d == StPlay);
      won_q    <= (state_d == StWon);
      over_q   <= (state_d == StLost);
    end
  end

  step_timer #(
    .W(SPEED_W)
  ) u_step_timer (
    .clk       (clk),
    .resetn    (resetn),
    .enable    (timer_en),
    .frame_tick(frame_tick),
    .limit     (speed_q),
    .step      (step)
  );

  assign speed_count = speed_q;
  assign num_blocks  = blocks_q;
  assign curr_level  = level_q;
  assign active      = active_q;
  assign game_won    = won_q;
  assign game_over   = over_q;

endmodule

// File: tb/tb_level_sequencer.sv
// Self-checking bench for level_sequencer against an arithmetic game model.
module tb_level_sequencer;

  logic       clk = 1'b0;
  logic       resetn, go, next_signal, miss, frame_tick;
  logic [5:0] speed_count;
  logic [2:0] num_blocks;
  logic [3:0] curr_level;
  logic       active, step, game_won, game_over;

  always #5 clk = ~clk;

  level_sequencer dut (
    .clk        (clk),
    .resetn     (resetn),
    .go         (go),
    .next_signal(next_signal),
    .miss       (miss),
    .frame_tick (frame_tick),
    .speed_count(speed_count),
    .num_blocks (num_blocks),
    .curr_level (curr_level),
    .active     (active),
    .step       (step),
    .game_won   (game_won),
    .game_over  (game_over)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Model: 0 wait, 1 play, 2 won, 3 lost.
  int m_state, m_level, m_ticks, m_step;

  function automatic int exp_speed(int lvl);
    int s = 60 - (lvl - 1) * 4;
    return (s < 6) ? 6 : s;
  endfunction

  function automatic int exp_blocks(int lvl);
    int b = 3 - (lvl - 1) / 5;
    return (b < 1) ? 1 : b;
  endfunction

  task automatic model_reset();
    m_state = 0; m_level = 1; m_ticks = 0; m_step = 0;
  endtask

  task automatic model_clock(input bit g, input bit n, input bit m, input bit t);
    m_step = 0;
    case (m_state)
      0: if (g) m_state = 1;
      1: begin
        if (m) m_state = 3;
        else if (n) begin
          if (m_level < 15) begin m_level++; m_state = 0; end
          else m_state = 2;
        end else if (t) begin
          m_ticks++;
          if (m_ticks == exp_speed(m_level)) begin m_ticks = 0; m_step = 1; end
        end
      end
      default: if (g) begin m_state = 0; m_level = 1; end
    endcase
    if (m_state != 1) m_ticks = 0;
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".level"},  int'(curr_level),  m_level);
    check_eq({tag, ".speed"},  int'(speed_count), exp_speed(m_level));
    check_eq({tag, ".blocks"}, int'(num_blocks),  exp_blocks(m_level));
    check_eq({tag, ".active"}, int'(active),      int'(m_state == 1));
    check_eq({tag, ".won"},    int'(game_won),    int'(m_state == 2));
    check_eq({tag, ".over"},   int'(game_over),   int'(m_state == 3));
    check_eq({tag, ".step"},   int'(step),        m_step);
  endtask

  // Inputs are driven just after a falling edge, outputs sampled at the next one.
  task automatic cyc(input string tag, input bit g, input bit n, input bit m, input bit t);
    go = g; next_signal = n; miss = m; frame_tick = t;
    @(posedge clk);
    model_clock(g, n, m, t);
    @(negedge clk);
    compare_all(tag);
  endtask

  task automatic do_reset();
    go = 0; next_signal = 0; miss = 0; frame_tick = 0;
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    resetn = 1'b0;
    compare_all("reset");
  endtask

  int steps_seen;

  initial begin
    resetn = 1'b1;
    go = 0; next_signal = 0; miss = 0; frame_tick = 0;
    @(negedge clk);
    do_reset();
    check_eq("rst_level", int'(curr_level), 1);
    check_eq("rst_speed", int'(speed_count), 60);
    check_eq("rst_blocks", int'(num_blocks), 3);

    // 30 ticks in WAIT produce no step.
    steps_seen = 0;
    for (int i = 0; i < 30; i++) begin
      cyc("wait_tick", 0, 0, 0, 1);
      steps_seen += int'(step);
    end
    check_eq("wait_no_step", steps_seen, 0);

    // 120 ticks at level 1, one every other cycle.
    cyc("go1", 1, 0, 0, 0);
    steps_seen = 0;
    for (int i = 1; i <= 120; i++) begin
      cyc("play_tick", 0, 0, 0, 1);
      if (i == 60 || i == 120) check_eq("step_after_tick", int'(step), 1);
      steps_seen += int'(step);
      cyc("play_idle", 0, 0, 0, 0);
      steps_seen += int'(step);
    end
    check_eq("step_count_120", steps_seen, 2);

    // Level clear at level 1.
    cyc("next1", 0, 1, 0, 0);
    check_eq("l2_level", int'(curr_level), 2);
    check_eq("l2_speed", int'(speed_count), 56);
    check_eq("l2_active", int'(active), 0);
    cyc("go2", 1, 0, 0, 0);
    check_eq("l2_go_active", int'(active), 1);

    // Clear every level from a fresh start.
    do_reset();
    for (int lvl = 1; lvl <= 15; lvl++) begin
      cyc("sweep_go", 1, 0, 0, 0);
      check_eq("sweep_blocks", int'(num_blocks), (lvl <= 5) ? 3 : (lvl <= 10) ? 2 : 1);
      if (lvl == 14) check_eq("l14_speed", int'(speed_count), 8);
      if (lvl == 15) check_eq("l15_speed", int'(speed_count), 6);
      cyc("sweep_next", 0, 1, 0, 0);
    end
    check_eq("won", int'(game_won), 1);
    check_eq("won_level", int'(curr_level), 15);
    cyc("won_go", 1, 0, 0, 0);
    check_eq("won_go_level", int'(curr_level), 1);

    // miss beats next_signal at level 7.
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc("to7_go", 1, 0, 0, 0);
      cyc("to7_next", 0, 1, 0, 0);
    end
    cyc("l7_go", 1, 0, 0, 0);
    cyc("l7_miss", 0, 1, 1, 0);
    check_eq("miss_over", int'(game_over), 1);
    check_eq("miss_level", int'(curr_level), 7);
    cyc("lost_go", 1, 0, 0, 0);
    check_eq("lost_go_level", int'(curr_level), 1);
    check_eq("lost_go_active", int'(active), 0);

    // Asynchronous reset between edges with the timer at 59.
    do_reset();
    cyc("ar_go", 1, 0, 0, 0);
    for (int i = 0; i < 59; i++) cyc("ar_tick", 0, 0, 0, 1);
    go = 0; next_signal = 0; miss = 0; frame_tick = 1;
    #2 resetn = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    #1 resetn = 1'b0;
    for (int i = 0; i < 4; i++) cyc("ar_after", (i == 1), 0, 0, 1);
    check_eq("ar_level", int'(curr_level), 1);

    // Randomized play against the model.
    do_reset();
    for (int i = 0; i < 20000; i++) begin
      cyc("rand", ($urandom_range(3) == 0), ($urandom_range(99) == 0),
          ($urandom_range(399) == 0), ($urandom_range(1) == 1));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
